// File: rtl/rc_link_pkg.sv
// Shared definitions for the redundancy-link receive path: CRC-8 constants,
// the frame checker state encoding and the byte-parallel CRC-8 update.
package rc_link_pkg;

    // CRC-8 with polynomial x^8+x^2+x+1, MSB-first, no reflection, no final XOR
    localparam logic [7:0] CRC8_POLY    = 8'h07;
    localparam logic [7:0] CRC8_INIT    = 8'h00;
    localparam logic [7:0] CRC8_RESIDUE = 8'h00;

    // Frame checker states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // One whole byte through the CRC in a single step. The data byte is folded
    // into the register first, then the eight shifts are collapsed into XOR
    // equations of the folded value t.
    function automatic logic [7:0] crc8Byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] t;
        logic [7:0] n;
        t    = crc ^ data;
        n[0] = t[0] ^ t[6] ^ t[7];
        n[1] = t[0] ^ t[1] ^ t[6];
        n[2] = t[0] ^ t[1] ^ t[2] ^ t[6];
        n[3] = t[1] ^ t[2] ^ t[3] ^ t[7];
        n[4] = t[2] ^ t[3] ^ t[4];
        n[5] = t[3] ^ t[4] ^ t[5];
        n[6] = t[4] ^ t[5] ^ t[6];
        n[7] = t[5] ^ t[6] ^ t[7];
        return n;
    endfunction

endpackage

// File: rtl/rc_crc8_byte.sv
// Byte-parallel CRC-8 engine. A set clear input makes the current byte start
// from the initial value instead of the running register, so a new frame never
// inherits residue from the previous one. The register only moves on valid.
module rc_crc8_byte
    import rc_link_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       vld_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_next_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [7:0] seed;

    // Next CRC value: seed from init on the first byte of a frame, else running value
    always_comb begin
        seed  = clr_i ? CRC8_INIT : crc_q;
        crc_d = crc8Byte(seed, data_i);
    end

    // Running CRC register, advanced only for accepted bytes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC8_INIT;
        end else if (vld_i) begin
            crc_q <= crc_d;
        end
    end

    // The checker needs the residue including the byte being accepted right now
    assign crc_next_o = crc_d;

endmodule

// File: rtl/rc_frame_crc_chk.sv
// Receive-side frame checker. Strips the trailing CRC byte from each sop/eop
// framed byte stream, forwards the payload through a one-byte hold register,
// produces a one-cycle verdict per frame and keeps saturating statistics.
module rc_frame_crc_chk
    import rc_link_pkg::*;
#(
    parameter int MIN_LEN = 2,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic [7:0]       rx_data,
    input  logic             rx_vld,
    input  logic             rx_sop,
    input  logic             rx_eop,
    input  logic             cnt_clr,
    output logic [7:0]       out_data,
    output logic             out_vld,
    output logic             out_sop,
    output logic             out_eop,
    output logic             frm_done,
    output logic             frm_ok,
    output logic             frm_crc_err,
    output logic             frm_len_err,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] crc_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt
);

    // The byte counter only needs to tell "too long" apart, so it stops at MAX_LEN+1
    localparam int               LEN_W   = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state_q;
    logic [LEN_W-1:0] byteCnt_q;
    logic [7:0]       hold_q;

    logic [7:0]       outData_q;
    logic             outVld_q;
    logic             outSop_q;
    logic             outEop_q;
    logic             done_q;
    logic             vOk_q;
    logic             vCrcErr_q;
    logic             vLenErr_q;

    logic [CNT_W-1:0] okCnt_q;
    logic [CNT_W-1:0] crcErrCnt_q;
    logic [CNT_W-1:0] lenErrCnt_q;

    logic             accept;
    logic [LEN_W-1:0] lenInc;
    logic [LEN_W-1:0] frmLen;
    logic             lenBad;
    logic             crcBad;
    logic [7:0]       crcNext;

    // CRC over every accepted frame byte; a sop byte restarts from the init value
    rc_crc8_byte u_crc (
        .clk_i      (clk_sys),
        .rst_i      (rst_sys),
        .clr_i      (rx_sop),
        .vld_i      (accept),
        .data_i     (rx_data),
        .crc_next_o (crcNext)
    );

    // Acceptance and verdict terms for the byte presented this cycle
    always_comb begin
        accept = rx_vld && (rx_sop || (state_q == RECV));
        lenInc = (byteCnt_q == LEN_SAT) ? LEN_SAT : byteCnt_q + LEN_ONE;
        frmLen = rx_sop ? LEN_ONE : lenInc;
        lenBad = (frmLen < LEN_MIN) || (frmLen > LEN_MAX);
        crcBad = (crcNext != CRC8_RESIDUE);
    end

    // Frame FSM with hold-register forwarding and registered verdict strobes
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q   <= IDLE;
            byteCnt_q <= '0;
            hold_q    <= '0;
            outData_q <= '0;
            outVld_q  <= 1'b0;
            outSop_q  <= 1'b0;
            outEop_q  <= 1'b0;
            done_q    <= 1'b0;
            vOk_q     <= 1'b0;
            vCrcErr_q <= 1'b0;
            vLenErr_q <= 1'b0;
        end else begin
            outVld_q  <= 1'b0;
            outSop_q  <= 1'b0;
            outEop_q  <= 1'b0;
            done_q    <= 1'b0;
            vOk_q     <= 1'b0;
            vCrcErr_q <= 1'b0;
            vLenErr_q <= 1'b0;

            if (accept) begin
                hold_q <= rx_data;
                if (rx_sop) begin
                    // A sop always opens a fresh frame; the held byte of any
                    // unfinished frame is dropped rather than emitted.
                    byteCnt_q <= LEN_ONE;
                    if (state_q == RECV) begin
                        // Aborted frame. If the new byte also carries eop, the
                        // single length error covers both frames.
                        done_q    <= 1'b1;
                        vLenErr_q <= 1'b1;
                    end else if (rx_eop) begin
                        done_q    <= 1'b1;
                        vLenErr_q <= lenBad;
                        vCrcErr_q <= !lenBad && crcBad;
                        vOk_q     <= !lenBad && !crcBad;
                    end
                    state_q <= rx_eop ? IDLE : RECV;
                end else begin
                    // A later byte of the same frame releases the held byte
                    byteCnt_q <= lenInc;
                    outVld_q  <= 1'b1;
                    outData_q <= hold_q;
                    outSop_q  <= (byteCnt_q == LEN_ONE);
                    outEop_q  <= rx_eop;
                    if (rx_eop) begin
                        done_q    <= 1'b1;
                        vLenErr_q <= lenBad;
                        vCrcErr_q <= !lenBad && crcBad;
                        vOk_q     <= !lenBad && !crcBad;
                        state_q   <= IDLE;
                    end
                end
            end
        end
    end

    // Saturating statistics; a clear in the same cycle as a verdict wins
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            okCnt_q     <= '0;
            crcErrCnt_q <= '0;
            lenErrCnt_q <= '0;
        end else if (cnt_clr) begin
            okCnt_q     <= '0;
            crcErrCnt_q <= '0;
            lenErrCnt_q <= '0;
        end else if (done_q) begin
            if (vOk_q && (okCnt_q != '1)) begin
                okCnt_q <= okCnt_q + 1'b1;
            end
            if (vCrcErr_q && (crcErrCnt_q != '1)) begin
                crcErrCnt_q <= crcErrCnt_q + 1'b1;
            end
            if (vLenErr_q && (lenErrCnt_q != '1)) begin
                lenErrCnt_q <= lenErrCnt_q + 1'b1;
            end
        end
    end

    assign out_data    = outData_q;
    assign out_vld     = outVld_q;
    assign out_sop     = outSop_q;
    assign out_eop     = outEop_q;
    assign frm_done    = done_q;
    assign frm_ok      = vOk_q;
    assign frm_crc_err = vCrcErr_q;
    assign frm_len_err = vLenErr_q;
    assign ok_cnt      = okCnt_q;
    assign crc_err_cnt = crcErrCnt_q;
    assign len_err_cnt = lenErrCnt_q;

endmodule

// File: tb/tb_rc_frame_crc_chk.sv
// Directed bench for rc_frame_crc_chk. A second instance with 2-bit counters
// sees the same stimulus so counter saturation is reachable in a short run.
`timescale 1ns/1ps
module tb_rc_frame_crc_chk;

    localparam int MIN_LEN = 2;
    localparam int MAX_LEN = 256;
    localparam int CNT_W   = 16;
    localparam int SMALL_W = 2;

    logic               clk_sys = 1'b0;
    logic               rst_sys = 1'b1;
    logic [7:0]         rx_data = '0;
    logic               rx_vld  = 1'b0;
    logic               rx_sop  = 1'b0;
    logic               rx_eop  = 1'b0;
    logic               cnt_clr = 1'b0;

    logic [7:0]         out_data;
    logic               out_vld, out_sop, out_eop;
    logic               frm_done, frm_ok, frm_crc_err, frm_len_err;
    logic [CNT_W-1:0]   ok_cnt, crc_err_cnt, len_err_cnt;

    logic [7:0]         sData;
    logic               sVld, sSop, sEop, sDone, sOk, sCrcErr, sLenErr;
    logic [SMALL_W-1:0] sOkCnt, sCrcErrCnt, sLenErrCnt;

    int checks      = 0;
    int failures    = 0;
    int strayEvents = 0;
    int cyc         = 0;

    logic [7:0] frm[$];
    logic [7:0] outData[$];
    logic       outSop[$];
    logic       outEop[$];
    int         outCyc[$];
    logic [2:0] verdictQ[$];
    int         verdictCyc[$];
    int         accCyc[$];

    rc_frame_crc_chk #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .cnt_clr(cnt_clr),
        .out_data(out_data), .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop),
        .frm_done(frm_done), .frm_ok(frm_ok), .frm_crc_err(frm_crc_err), .frm_len_err(frm_len_err),
        .ok_cnt(ok_cnt), .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt)
    );

    rc_frame_crc_chk #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(SMALL_W)) dutSmall (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .cnt_clr(cnt_clr),
        .out_data(sData), .out_vld(sVld), .out_sop(sSop), .out_eop(sEop),
        .frm_done(sDone), .frm_ok(sOk), .frm_crc_err(sCrcErr), .frm_len_err(sLenErr),
        .ok_cnt(sOkCnt), .crc_err_cnt(sCrcErrCnt), .len_err_cnt(sLenErrCnt)
    );

    // 125 MHz system clock
    always #4 clk_sys = ~clk_sys;

    // Cycle index, read away from the edge by the monitor and the drivers
    always @(posedge clk_sys) cyc = cyc + 1;

    // Capture emitted payload and verdicts on the falling edge
    always @(negedge clk_sys) begin
        if (!rst_sys) begin
            if (out_vld) begin
                outData.push_back(out_data);
                outSop.push_back(out_sop);
                outEop.push_back(out_eop);
                outCyc.push_back(cyc);
            end
            if (frm_done) begin
                verdictQ.push_back({frm_ok, frm_crc_err, frm_len_err});
                verdictCyc.push_back(cyc);
            end else if (frm_ok || frm_crc_err || frm_len_err) begin
                strayEvents++;
            end
            if (!out_vld && (out_sop || out_eop)) strayEvents++;
            if ({sVld, sSop, sEop, sDone, sOk, sCrcErr, sLenErr} !==
                {out_vld, out_sop, out_eop, frm_done, frm_ok, frm_crc_err, frm_len_err}) strayEvents++;
            if (out_vld && (sData !== out_data)) strayEvents++;
        end
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bit-serial reference CRC-8, MSB first, polynomial 0x07
    function automatic logic [7:0] crc8Serial(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ d[b];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    function automatic int sat(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk_sys);
        rx_data = d; rx_vld = 1'b1; rx_sop = s; rx_eop = e;
        @(posedge clk_sys);
        #1;
        accCyc.push_back(cyc);
        rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clearQueues();
        outData.delete(); outSop.delete(); outEop.delete(); outCyc.delete();
        verdictQ.delete(); verdictCyc.delete(); accCyc.delete();
    endtask

    // Send frm with sop on the first and eop on the last byte, optional idle gaps
    task automatic sendFrame(input bit withGaps);
        clearQueues();
        for (int i = 0; i < frm.size(); i++) begin
            applyStimulus(frm[i], i == 0, i == frm.size() - 1);
            if (withGaps && (i % 3 == 1)) idleCycles(1 + (i % 2));
        end
        idleCycles(4);
    endtask

    // Payload is everything but the CRC byte; byte k leaves when byte k+1 is accepted
    task automatic checkFrame(input string tag, input logic [2:0] expVerdict);
        int n;
        n = frm.size() - 1;
        checkOutput({tag, " outCount"}, outData.size(), n);
        for (int k = 0; k < n && k < outData.size(); k++) begin
            checkOutput($sformatf("%s data%0d", tag, k), outData[k], frm[k]);
            checkOutput($sformatf("%s sopEop%0d", tag, k), {outSop[k], outEop[k]}, {k == 0, k == n - 1});
            checkOutput($sformatf("%s outCyc%0d", tag, k), outCyc[k], accCyc[k + 1]);
        end
        checkOutput({tag, " verdictCount"}, verdictQ.size(), 1);
        if (verdictQ.size() > 0) begin
            checkOutput({tag, " verdict"}, verdictQ[0], expVerdict);
            checkOutput({tag, " verdictCyc"}, verdictCyc[0], accCyc[n] + 1 - 1);
        end
    endtask

    task automatic checkCounters(input string tag, input int expOk, input int expCrc, input int expLen);
        checkOutput({tag, " okCnt"}, ok_cnt, expOk);
        checkOutput({tag, " crcErrCnt"}, crc_err_cnt, expCrc);
        checkOutput({tag, " lenErrCnt"}, len_err_cnt, expLen);
        checkOutput({tag, " smallOkCnt"}, sOkCnt, sat(expOk));
        checkOutput({tag, " smallCrcErrCnt"}, sCrcErrCnt, sat(expCrc));
        checkOutput({tag, " smallLenErrCnt"}, sLenErrCnt, sat(expLen));
    endtask

    // Frame of payloadLen bytes followed by its correct CRC
    task automatic buildFrame(input int payloadLen);
        logic [7:0] c;
        frm.delete();
        c = 8'h00;
        for (int i = 0; i < payloadLen; i++) begin
            frm.push_back(8'(i) ^ 8'h5A);
            c = crc8Serial(c, 8'(i) ^ 8'h5A);
        end
        frm.push_back(c);
    endtask

    // Directed sequence; verdict encoding is {ok, crcErr, lenErr}
    initial begin
        #10;
        checkOutput("reset outputs", {out_vld, out_sop, out_eop, frm_done, frm_ok, frm_crc_err, frm_len_err}, 7'd0);
        checkOutput("reset outData", out_data, 8'h00);
        checkCounters("reset", 0, 0, 0);
        @(negedge clk_sys);
        rst_sys = 1'b0;
        idleCycles(2);

        // Minimal good frame 0x01 followed by CRC 0x07
        frm = '{8'h01, 8'h07};
        sendFrame(1'b0);
        checkFrame("min", 3'b100);
        checkCounters("min", 1, 0, 0);

        // Check string "123456789" with its known CRC 0xF4, back to back
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(8'hF4);
        sendFrame(1'b0);
        checkFrame("check", 3'b100);
        checkCounters("check", 2, 0, 0);

        // Same frame with idle gaps; output gaps must track input gaps
        sendFrame(1'b1);
        checkFrame("gaps", 3'b100);
        checkCounters("gaps", 3, 0, 0);

        // Corrupted CRC byte
        frm[9] = 8'hF5;
        sendFrame(1'b0);
        checkFrame("crcErr", 3'b010);
        checkCounters("crcErr", 3, 1, 0);

        // Single byte frame carrying sop and eop together
        frm = '{8'h55};
        sendFrame(1'b0);
        checkFrame("single", 3'b001);
        checkCounters("single", 3, 1, 1);

        // Longest legal frame, small instance ok counter already at its ceiling
        buildFrame(MAX_LEN - 1);
        sendFrame(1'b0);
        checkFrame("maxLen", 3'b100);
        checkCounters("maxLen", 4, 1, 1);

        // One byte too long, correct CRC, still forwarded
        buildFrame(MAX_LEN);
        sendFrame(1'b0);
        checkFrame("overLen", 3'b001);
        checkCounters("overLen", 4, 1, 2);

        // Frame A aborted by a sop after three bytes, then good frame B
        clearQueues();
        applyStimulus(8'hA1, 1'b1, 1'b0);
        applyStimulus(8'hA2, 1'b0, 1'b0);
        applyStimulus(8'hA3, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h07, 1'b0, 1'b1);
        idleCycles(4);
        checkOutput("abort outCount", outData.size(), 3);
        if (outData.size() == 3) begin
            checkOutput("abort data0", outData[0], 8'hA1);
            checkOutput("abort data1", outData[1], 8'hA2);
            checkOutput("abort data2", outData[2], 8'h01);
            checkOutput("abort flags0", {outSop[0], outEop[0]}, 2'b10);
            checkOutput("abort flags1", {outSop[1], outEop[1]}, 2'b00);
            checkOutput("abort flags2", {outSop[2], outEop[2]}, 2'b11);
        end
        checkOutput("abort verdictCount", verdictQ.size(), 2);
        if (verdictQ.size() == 2) begin
            checkOutput("abort verdictA", verdictQ[0], 3'b001);
            checkOutput("abort verdictACyc", verdictCyc[0], accCyc[3]);
            checkOutput("abort verdictB", verdictQ[1], 3'b100);
            checkOutput("abort verdictBCyc", verdictCyc[1], accCyc[4]);
        end
        checkCounters("abort", 5, 1, 3);

        // Bytes without sop in IDLE and control bits without valid are ignored
        clearQueues();
        applyStimulus(8'h33, 1'b0, 1'b0);
        applyStimulus(8'h44, 1'b0, 1'b1);
        @(negedge clk_sys);
        rx_sop = 1'b1; rx_eop = 1'b1; rx_data = 8'h99;
        @(posedge clk_sys);
        #1;
        rx_sop = 1'b0; rx_eop = 1'b0;
        idleCycles(3);
        checkOutput("ignore outCount", outData.size(), 0);
        checkOutput("ignore verdictCount", verdictQ.size(), 0);
        frm = '{8'h01, 8'h07};
        sendFrame(1'b0);
        checkFrame("afterIgnore", 3'b100);
        checkCounters("afterIgnore", 6, 1, 3);

        // Asynchronous reset in the middle of a frame
        clearQueues();
        applyStimulus(8'h10, 1'b1, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        checkOutput("preReset outVld", out_vld, 1'b1);
        #1;
        rst_sys = 1'b1;
        #1;
        checkOutput("midReset outputs", {out_vld, out_sop, out_eop, frm_done, frm_ok, frm_crc_err, frm_len_err}, 7'd0);
        checkOutput("midReset outData", out_data, 8'h00);
        checkCounters("midReset", 0, 0, 0);
        idleCycles(2);
        rst_sys = 1'b0;
        frm = '{8'h00, 8'h00};
        sendFrame(1'b0);
        checkFrame("postReset", 3'b100);
        checkCounters("postReset", 1, 0, 0);

        // Plain counter clear
        @(negedge clk_sys);
        cnt_clr = 1'b1;
        @(posedge clk_sys);
        #1;
        cnt_clr = 1'b0;
        checkCounters("clear", 0, 0, 0);

        // Clear coinciding with a verdict strobe wins over the increment
        clearQueues();
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h07, 1'b0, 1'b1);
        checkOutput("clrRace done", frm_done, 1'b1);
        cnt_clr = 1'b1;
        @(posedge clk_sys);
        #1;
        cnt_clr = 1'b0;
        idleCycles(2);
        checkCounters("clrRace", 0, 0, 0);

        // Counting resumes after a clear
        frm = '{8'h01, 8'h07};
        sendFrame(1'b0);
        checkFrame("afterClear", 3'b100);
        checkCounters("afterClear", 1, 0, 0);

        checkOutput("stray events", strayEvents, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
